// File: rtl/ooo_pkg.sv
// Shared types for the front end: fetch-queue entry layout and fetch FSM states.
package ooo_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, instr} pairs between fetch and issue.
// A flush empties the buffer and overrides any same-cycle push or pop.
module fetch_queue
    import ooo_pkg::*;
#(
    parameter int FQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  fq_entry_t                   push_data,
    input  logic                        pop,
    input  logic                        flush,
    output fq_entry_t                   head_data,
    output logic [$clog2(FQ_DEPTH):0]   count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [FQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FQ_DEPTH));
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;
    assign head_data = mem[head];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps one instruction-memory request in
// flight and buffers returned words for issue. Redirects flush everything.
//
// state | meaning
// FETCH | may issue a request for pc when the queue has room
// WAIT  | one request accepted, response will be pushed into the queue
// DROP  | one request accepted but made stale by a redirect; response discarded
module fetch_unit
    import ooo_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fq_valid,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_instr,
    input  logic        fq_ready
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    fq_entry_t        push_entry;
    fq_entry_t        head;
    logic [CNT_W-1:0] fq_count;
    logic             fq_empty;
    logic             fq_full;
    logic             push;
    logic             pop;

    // Requesting only below full keeps a slot free for the single in-flight response.
    assign imem_req_valid = (state == FETCH) && (fq_count < CNT_W'(FQ_DEPTH)) && !redirect_valid;
    assign imem_addr      = {pc[31:2], 2'b00};

    assign push       = (state == WAIT) && imem_resp_valid && !redirect_valid && !fq_full;
    assign pop        = fq_ready && !fq_empty && !redirect_valid;
    assign push_entry = '{pc: req_pc, instr: imem_resp_data};

    assign fq_valid = !fq_empty;
    assign fq_pc    = head.pc;
    assign fq_instr = head.instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'h0000_0003;
            case (state)
                FETCH:   state <= FETCH;
                WAIT:    state <= imem_resp_valid ? FETCH : DROP;
                DROP:    state <= imem_resp_valid ? FETCH : DROP;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req_valid && imem_req_ready) begin
                        req_pc <= pc;
                        pc     <= pc + 32'(INSTR_BYTES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) state <= FETCH;
                end
                DROP: begin
                    if (imem_resp_valid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (fq_count),
        .empty     (fq_empty),
        .full      (fq_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-memory model, expected-entry scoreboard
// fed by the stimulus, and a monitor that checks every entry issue pops.
module tb_fetch_unit;
    import ooo_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fq_valid;
    logic [31:0] fq_pc;
    logic [31:0] fq_instr;
    logic        fq_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    int lat     = 1;

    fq_entry_t exp_q[$];

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fq_valid        (fq_valid),
        .fq_pc           (fq_pc),
        .fq_instr        (fq_instr),
        .fq_ready        (fq_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A00_00A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_from(input logic [31:0] start, input int n);
        fq_entry_t e;
        logic [31:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = a;
            e.instr = mem_word(a);
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    task automatic wait_pops(input int n, input string name);
        int  start;
        bit  ok;
        start = pop_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pop_cnt >= start + n) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: delivered %0d entries, required %0d", name, pop_cnt - start, n);
        end
    endtask

    task automatic wait_accept(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) tick();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: no request accepted, required one", name);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        fq_ready       = 1'b0;
        lat            = 1;
        tick();
        tick();
        expect_from(RESET_PC, 16);
        rst_n = 1'b1;
    endtask

    // Memory model: responds `lat` cycles after acceptance, forgets on reset.
    logic        mem_pend = 1'b0;
    int          mem_rem  = 0;
    logic [31:0] mem_addr = '0;
    initial begin
        logic        acc;
        logic        rs;
        logic [31:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            acc = imem_req_valid && imem_req_ready;
            a   = imem_addr;
            rs  = rst_n;
            #1;
            imem_resp_valid = 1'b0;
            if (!rs) begin
                mem_pend = 1'b0;
            end else begin
                if (acc) begin
                    mem_pend = 1'b1;
                    mem_rem  = lat;
                    mem_addr = a;
                end
                if (mem_pend) begin
                    if (mem_rem <= 1) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_word(mem_addr);
                        mem_pend        = 1'b0;
                    end else begin
                        mem_rem--;
                    end
                end
            end
        end
    end

    // Monitor: every accepted pop must match the next expected entry.
    always @(negedge clk) begin
        fq_entry_t e;
        if (rst_n && !redirect_valid && fq_valid && fq_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc 0x%08h, required no entry", fq_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", fq_pc, e.pc);
                check("pop_instr", fq_instr, e.instr);
            end
            pop_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;

        // Reset state
        do_reset();
        #1;
        check("rst_req_valid", imem_req_valid, 1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_fq_valid", fq_valid, 0);

        // Streaming: always ready, 1-cycle latency
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;
        wait_pops(4, "stream");

        // Back-pressure: queue saturates, no request while full
        do_reset();
        imem_req_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut.fq_count > 4) bad = 1'b1;
            if (dut.fq_count == 4 && imem_req_valid) bad = 1'b1;
        end
        check("full_count", 32'(dut.fq_count), 4);
        check("full_req_valid", imem_req_valid, 0);
        check("full_no_req_seen", 32'(bad), 0);
        fq_ready = 1'b1;
        wait_pops(5, "drain_then_fetch");

        // Redirect while WAIT, stale response one cycle later
        do_reset();
        lat            = 2;
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;
        wait_accept("wait_redirect_accept");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        expect_from(32'h0000_0100, 16);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drop_state", 32'(dut.state), 32'(DROP));
        check("drop_req_valid", imem_req_valid, 0);
        tick();
        #1;
        check("after_drop_valid", imem_req_valid, 1);
        check("after_drop_addr", imem_addr, 32'h0000_0100);
        wait_pops(2, "after_drop_stream");

        // Redirect in the same cycle as a response and a pop
        do_reset();
        imem_req_ready = 1'b1;
        bad = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            #1;
            if (imem_resp_valid && fq_valid) begin
                bad = 1'b0;
                break;
            end
        end
        check("resp_pop_setup", 32'(bad), 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        fq_ready       = 1'b1;
        expect_from(32'h0000_0200, 16);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("flush_fq_valid", fq_valid, 0);
        check("flush_count", 32'(dut.fq_count), 0);
        check("flush_state", 32'(dut.state), 32'(FETCH));
        check("flush_addr", imem_addr, 32'h0000_0200);
        wait_pops(2, "after_flush_stream");

        // Misaligned redirect target
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        check("redirect_blocks_req", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("align_addr", imem_addr, 32'h0000_0200);
        check("align_req_valid", imem_req_valid, 1);
        expect_from(32'h0000_0200, 16);
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;
        wait_pops(2, "align_stream");

        // PC wrap at the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        expect_from(32'hFFFF_FFFC, 16);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;
        wait_accept("wrap_accept");
        check("wrap_addr", imem_addr, 32'h0000_0000);
        wait_pops(3, "wrap_stream");

        // Request held while memory stalls
        do_reset();
        fq_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!imem_req_valid || imem_addr !== RESET_PC) bad = 1'b1;
        end
        check("stall_stable", 32'(bad), 0);
        imem_req_ready = 1'b1;
        wait_pops(2, "stall_release_stream");

        // Reset while a request is outstanding
        do_reset();
        lat            = 3;
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;
        wait_accept("rst_wait_accept");
        check("pre_rst_state", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lat   = 1;
        expect_from(RESET_PC, 16);
        #1;
        check("rst_wait_state", 32'(dut.state), 32'(FETCH));
        check("rst_wait_count", 32'(dut.fq_count), 0);
        check("rst_wait_addr", imem_addr, RESET_PC);
        wait_pops(2, "rst_wait_stream");

        fq_ready       = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
